// File: rtl/tl_pkg.sv
// tl_pkg: shared definitions for the intersection scheduler.
//   - tl_state_t : phase/state codes (also driven on the phase output)
//   - TL_GREEN / TL_YELLOW / TL_RED : one-hot signal head encodings
//   - default phase durations in seconds
//   - tl_heads() : maps a state to the {NS, EW} head encodings
package tl_pkg;

  typedef enum logic [2:0] {
    ST_INIT_RED  = 3'd0,
    ST_NS_GREEN  = 3'd1,
    ST_NS_YELLOW = 3'd2,
    ST_NS_CLEAR  = 3'd3,
    ST_EW_GREEN  = 3'd4,
    ST_EW_YELLOW = 3'd5,
    ST_EW_CLEAR  = 3'd6
  } tl_state_t;

  localparam logic [2:0] TL_GREEN  = 3'b001;
  localparam logic [2:0] TL_YELLOW = 3'b010;
  localparam logic [2:0] TL_RED    = 3'b100;

  localparam logic [7:0] TL_GREEN_TIME_DEF  = 8'd20;
  localparam logic [7:0] TL_YELLOW_TIME_DEF = 8'd3;
  localparam logic [7:0] TL_ALLRED_TIME_DEF = 8'd2;
  localparam logic [7:0] TL_PED_TIME_DEF    = 8'd10;

  // Returns {ns_head, ew_head}. Any state not listed (INIT_RED, CLEAR
  // states, illegal codes) is all-red, so both heads can never be
  // non-red at the same time.
  function automatic logic [5:0] tl_heads(input tl_state_t s);
    case (s)
      ST_NS_GREEN:  tl_heads = {TL_GREEN,  TL_RED};
      ST_NS_YELLOW: tl_heads = {TL_YELLOW, TL_RED};
      ST_EW_GREEN:  tl_heads = {TL_RED,    TL_GREEN};
      ST_EW_YELLOW: tl_heads = {TL_RED,    TL_YELLOW};
      default:      tl_heads = {TL_RED,    TL_RED};
    endcase
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// tl_phase_timer: 8-bit loadable down-counter for phase timing.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (count <= RESET_VAL)
//   i_tick        1 s strobe; decrements while count > 1
//   i_hold        freezes the count and suppresses expiry
//   i_load        load i_load_val (takes priority over counting)
//   i_load_val    value to load
//   o_count       current count (registered, never 0 with legal loads)
//   o_expire      count == 1 and an un-held tick this cycle
module tl_phase_timer
  import tl_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = TL_ALLRED_TIME_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_hold,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic [7:0] o_count,
  output logic       o_expire
);

  logic [7:0] r_count;

  assign o_count  = r_count;
  assign o_expire = i_tick && !i_hold && (r_count == 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= RESET_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && !i_hold && (r_count > 8'd1)) begin
      r_count <= r_count - 8'd1;
    end
  end

endmodule

// File: rtl/tl_intersection_scheduler.sv
// tl_intersection_scheduler: two-road traffic light sequencer with latched
// pedestrian requests. Cycle: INIT_RED -> NS_GREEN -> NS_YELLOW -> NS_CLEAR
// -> EW_GREEN -> EW_YELLOW -> EW_CLEAR -> NS_GREEN. Timers advance on tick_1s.
// Optional feature macro: TL_EMERGENCY_EN (adds emerg_req preemption).
// Ports:
//   sys_clk, sys_rst_p       clock, asynchronous active-high reset
//   tick_1s                  one-cycle 1 s strobe
//   ped_req_ns, ped_req_ew   pedestrian requests (any width, rising edge latched)
//   emerg_req                emergency preemption level (TL_EMERGENCY_EN only)
//   light_ns, light_ew       one-hot heads: 001 green, 010 yellow, 100 red
//   walk_ns, walk_ew         walk grants
//   light_t                  seconds remaining in current phase
//   phase                    current state code
module tl_intersection_scheduler
  import tl_pkg::*;
#(
  parameter logic [7:0] GREEN_TIME  = TL_GREEN_TIME_DEF,
  parameter logic [7:0] YELLOW_TIME = TL_YELLOW_TIME_DEF,
  parameter logic [7:0] ALLRED_TIME = TL_ALLRED_TIME_DEF,
  parameter logic [7:0] PED_TIME    = TL_PED_TIME_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_p,
  input  logic       tick_1s,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
`ifdef TL_EMERGENCY_EN
  input  logic       emerg_req,
`endif
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [7:0] light_t,
  output logic [2:0] phase
);

  // Walk ends on the tick that takes light_t from this value down to
  // GREEN_TIME-PED_TIME, i.e. after PED_TIME ticks of green.
  localparam logic [7:0] WALK_LAST_T = GREEN_TIME - PED_TIME + 8'd1;

  tl_state_t  r_state;
  logic [2:0] r_light_ns, r_light_ew;
  logic       r_walk_ns, r_walk_ew;
  logic       r_pend_ns, r_pend_ew;
  logic       r_req_ns_prev, r_req_ew_prev;

  tl_state_t  w_next_state;
  logic       w_load, w_hold, w_expire;
  logic [7:0] w_load_val, w_light_t;
  logic       w_rise_ns, w_rise_ew, w_enter_ns, w_enter_ew, w_walk_end;

  function automatic logic [7:0] duration(input tl_state_t s);
    case (s)
      ST_NS_GREEN, ST_EW_GREEN:   duration = GREEN_TIME;
      ST_NS_YELLOW, ST_EW_YELLOW: duration = YELLOW_TIME;
      default:                    duration = ALLRED_TIME;
    endcase
  endfunction

  // Kept apart from the next-state block: the timer's expiry depends on hold.
`ifdef TL_EMERGENCY_EN
  assign w_hold = emerg_req && ((r_state == ST_INIT_RED) ||
                                (r_state == ST_NS_CLEAR) ||
                                (r_state == ST_EW_CLEAR));
`else
  assign w_hold = 1'b0;
`endif

  tl_phase_timer #(.RESET_VAL(ALLRED_TIME)) u_timer (
    .clk        (sys_clk),
    .rst        (sys_rst_p),
    .i_tick     (tick_1s),
    .i_hold     (w_hold),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_count    (w_light_t),
    .o_expire   (w_expire)
  );

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = ALLRED_TIME;
    case (r_state)
      ST_INIT_RED:  if (w_expire) w_next_state = ST_NS_GREEN;
      ST_NS_GREEN:  if (w_expire) w_next_state = ST_NS_YELLOW;
      ST_NS_YELLOW: if (w_expire) w_next_state = ST_NS_CLEAR;
      ST_NS_CLEAR:  if (w_expire) w_next_state = ST_EW_GREEN;
      ST_EW_GREEN:  if (w_expire) w_next_state = ST_EW_YELLOW;
      ST_EW_YELLOW: if (w_expire) w_next_state = ST_EW_CLEAR;
      ST_EW_CLEAR:  if (w_expire) w_next_state = ST_NS_GREEN;
      default:      w_next_state = ST_INIT_RED;
    endcase
`ifdef TL_EMERGENCY_EN
    // Preemption cuts a running green short; yellow then completes normally.
    if (emerg_req && (r_state == ST_NS_GREEN)) w_next_state = ST_NS_YELLOW;
    if (emerg_req && (r_state == ST_EW_GREEN)) w_next_state = ST_EW_YELLOW;
`endif
    if (w_next_state != r_state) begin
      w_load     = 1'b1;
      w_load_val = duration(w_next_state);
    end
  end

  assign w_rise_ns  = ped_req_ns && !r_req_ns_prev;
  assign w_rise_ew  = ped_req_ew && !r_req_ew_prev;
  assign w_enter_ns = (w_next_state == ST_NS_GREEN) && (r_state != ST_NS_GREEN);
  assign w_enter_ew = (w_next_state == ST_EW_GREEN) && (r_state != ST_EW_GREEN);
  assign w_walk_end = tick_1s && (w_light_t == WALK_LAST_T);

  always_ff @(posedge sys_clk or posedge sys_rst_p) begin
    if (sys_rst_p) begin
      r_state       <= ST_INIT_RED;
      r_light_ns    <= TL_RED;
      r_light_ew    <= TL_RED;
      r_walk_ns     <= 1'b0;
      r_walk_ew     <= 1'b0;
      r_pend_ns     <= 1'b0;
      r_pend_ew     <= 1'b0;
      r_req_ns_prev <= 1'b0;
      r_req_ew_prev <= 1'b0;
    end else begin
      r_state                  <= w_next_state;
      {r_light_ns, r_light_ew} <= tl_heads(w_next_state);
      r_req_ns_prev            <= ped_req_ns;
      r_req_ew_prev            <= ped_req_ew;

      // A request rising on the entry edge is served by that green directly.
      if (w_enter_ns)     r_pend_ns <= 1'b0;
      else if (w_rise_ns) r_pend_ns <= 1'b1;
      if (w_enter_ew)     r_pend_ew <= 1'b0;
      else if (w_rise_ew) r_pend_ew <= 1'b1;

      if (w_enter_ns)                        r_walk_ns <= r_pend_ns || w_rise_ns;
      else if (w_next_state != ST_NS_GREEN)  r_walk_ns <= 1'b0;
      else if (w_walk_end)                   r_walk_ns <= 1'b0;

      if (w_enter_ew)                        r_walk_ew <= r_pend_ew || w_rise_ew;
      else if (w_next_state != ST_EW_GREEN)  r_walk_ew <= 1'b0;
      else if (w_walk_end)                   r_walk_ew <= 1'b0;
    end
  end

  assign light_ns = r_light_ns;
  assign light_ew = r_light_ew;
  assign walk_ns  = r_walk_ns;
  assign walk_ew  = r_walk_ew;
  assign light_t  = w_light_t;
  assign phase    = r_state;

endmodule
